// File: rtl/pwm_sequencer.sv
// Steps the PWM generator through a table of duty-cycle entries, updating
// PULSE/SIZE only on period boundaries tracked by a local period counter.
module pwm_sequencer #(
  parameter int N_ENTRIES = 8,
  parameter int AW        = $clog2(N_ENTRIES)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [31:0]   cfg_pulse,
  input  logic [7:0]    cfg_size,
  input  logic [15:0]   cfg_reps,
  input  logic [31:0]   period_i,
  input  logic [AW:0]   num_entries,
  input  logic          loop_en,
  input  logic          start,
  input  logic          stop,
  output logic [31:0]   PERIOD,
  output logic [31:0]   PULSE,
  output logic [7:0]    SIZE,
  output logic          ENABLE,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cur_idx
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [AW:0] NumMax = (AW+1)'(N_ENTRIES);

  state_e        state_q, state_d;
  logic [31:0]   period_q, period_d;
  logic [31:0]   pulse_q, pulse_d;
  logic [7:0]    size_q, size_d;
  logic          enable_q, enable_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [15:0]   rep_q, rep_d;
  logic [31:0]   pcnt_q, pcnt_d;
  logic [AW:0]   num_q, num_d;
  logic          loop_q, loop_d;
  logic          stop_pend_q, stop_pend_d;

  logic [31:0]   tbl_pulse_q [N_ENTRIES];
  logic [7:0]    tbl_size_q  [N_ENTRIES];
  logic [15:0]   tbl_reps_q  [N_ENTRIES];

  logic [AW-1:0] next_idx;
  logic          start_ok;
  logic          boundary;

  function automatic logic [15:0] reps_or_one(input logic [15:0] r);
    return (r == 16'd0) ? 16'd1 : r;
  endfunction

  // A load in the same cycle as a write to that entry sees the old contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        tbl_pulse_q[i] <= '0;
        tbl_size_q[i]  <= '0;
        tbl_reps_q[i]  <= '0;
      end
    end else if (cfg_we) begin
      tbl_pulse_q[cfg_addr] <= cfg_pulse;
      tbl_size_q[cfg_addr]  <= cfg_size;
      tbl_reps_q[cfg_addr]  <= cfg_reps;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      period_q    <= '0;
      pulse_q     <= '0;
      size_q      <= '0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      idx_q       <= '0;
      rep_q       <= '0;
      pcnt_q      <= '0;
      num_q       <= '0;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      pulse_q     <= pulse_d;
      size_q      <= size_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      idx_q       <= idx_d;
      rep_q       <= rep_d;
      pcnt_q      <= pcnt_d;
      num_q       <= num_d;
      loop_q      <= loop_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    pulse_d     = pulse_q;
    size_d      = size_q;
    enable_d    = enable_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    idx_d       = idx_q;
    rep_d       = rep_q;
    pcnt_d      = pcnt_q;
    num_d       = num_q;
    loop_d      = loop_q;
    stop_pend_d = stop_pend_q;

    next_idx = idx_q + AW'(1);
    start_ok = start && !stop && (num_entries != '0) && (num_entries <= NumMax)
               && (period_i >= 32'd2);
    boundary = (pcnt_q == period_q - 32'd1);

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d     = RUN;
          period_d    = period_i;
          pulse_d     = tbl_pulse_q[0];
          size_d      = tbl_size_q[0];
          idx_d       = '0;
          rep_d       = reps_or_one(tbl_reps_q[0]);
          pcnt_d      = '0;
          enable_d    = 1'b1;
          busy_d      = 1'b1;
          num_d       = num_entries;
          loop_d      = loop_en;
          stop_pend_d = 1'b0;
        end
      end
      RUN: begin
        pcnt_d = boundary ? 32'd0 : pcnt_q + 32'd1;
        if (!boundary) begin
          if (stop) stop_pend_d = 1'b1;
        end else if (stop_pend_q || stop) begin
          state_d     = IDLE;
          enable_d    = 1'b0;
          busy_d      = 1'b0;
          pulse_d     = '0;
          size_d      = '0;
          stop_pend_d = 1'b0;
        end else if (rep_q > 16'd1) begin
          rep_d = rep_q - 16'd1;
        end else if ({1'b0, idx_q} < num_q - (AW+1)'(1)) begin
          idx_d   = next_idx;
          pulse_d = tbl_pulse_q[next_idx];
          size_d  = tbl_size_q[next_idx];
          rep_d   = reps_or_one(tbl_reps_q[next_idx]);
        end else if (loop_q) begin
          idx_d   = '0;
          pulse_d = tbl_pulse_q[0];
          size_d  = tbl_size_q[0];
          rep_d   = reps_or_one(tbl_reps_q[0]);
        end else begin
          state_d     = IDLE;
          enable_d    = 1'b0;
          busy_d      = 1'b0;
          pulse_d     = '0;
          size_d      = '0;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PERIOD  = period_q;
    PULSE   = pulse_q;
    SIZE    = size_q;
    ENABLE  = enable_q;
    busy    = busy_q;
    done    = done_q;
    cur_idx = idx_q;
  end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed, table-driven bench for pwm_sequencer; expected values are
// hand-derived cycle positions relative to the start request.
module tb_pwm_sequencer;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [31:0]   cfg_pulse = '0;
  logic [7:0]    cfg_size = '0;
  logic [15:0]   cfg_reps = '0;
  logic [31:0]   period_i = '0;
  logic [AW:0]   num_entries = '0;
  logic          loop_en = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [31:0]   PERIOD, PULSE;
  logic [7:0]    SIZE;
  logic          ENABLE, busy, done;
  logic [AW-1:0] cur_idx;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    int          k;
    logic [31:0] expPulse;
    logic [2:0]  expIdx;
    logic        expEnable;
    logic        expDone;
  } rampVec_t;

  typedef struct {
    logic [3:0]  num;
    logic [31:0] period;
    logic        stopIn;
    logic        expBusy;
    logic [31:0] expPeriod;
    logic [31:0] expPulse;
  } startVec_t;

  rampVec_t  rampTbl  [10];
  startVec_t startTbl [5];

  pwm_sequencer #(.N_ENTRIES(N)) dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_pulse(cfg_pulse), .cfg_size(cfg_size), .cfg_reps(cfg_reps),
    .period_i(period_i), .num_entries(num_entries), .loop_en(loop_en),
    .start(start), .stop(stop), .PERIOD(PERIOD), .PULSE(PULSE), .SIZE(SIZE),
    .ENABLE(ENABLE), .busy(busy), .done(done), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " PERIOD"},  PERIOD, 32'd0);
    checkOutput({tag, " PULSE"},   PULSE, 32'd0);
    checkOutput({tag, " SIZE"},    32'(SIZE), 32'd0);
    checkOutput({tag, " ENABLE"},  32'(ENABLE), 32'd0);
    checkOutput({tag, " busy"},    32'(busy), 32'd0);
    checkOutput({tag, " done"},    32'(done), 32'd0);
    checkOutput({tag, " cur_idx"}, 32'(cur_idx), 32'd0);
  endtask

  task automatic writeEntry(input logic [AW-1:0] a, input logic [31:0] p,
                            input logic [7:0] s, input logic [15:0] r);
    cfg_we = 1'b1; cfg_addr = a; cfg_pulse = p; cfg_size = s; cfg_reps = r;
    tick();
    cfg_we = 1'b0;
  endtask

  // Returns at the first sample after the start edge (cycle k=1).
  task automatic applyStimulus(input logic [3:0] num, input logic [31:0] per,
                               input logic lp, input logic stp);
    num_entries = num; period_i = per; loop_en = lp;
    start = 1'b1; stop = stp;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checkOutput({name, " idle reached"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int curK;
    rampTbl[0] = '{1,  1, 0, 1'b1, 1'b0};
    rampTbl[1] = '{8,  1, 0, 1'b1, 1'b0};
    rampTbl[2] = '{9,  2, 1, 1'b1, 1'b0};
    rampTbl[3] = '{16, 2, 1, 1'b1, 1'b0};
    rampTbl[4] = '{17, 3, 2, 1'b1, 1'b0};
    rampTbl[5] = '{24, 3, 2, 1'b1, 1'b0};
    rampTbl[6] = '{25, 4, 3, 1'b1, 1'b0};
    rampTbl[7] = '{32, 4, 3, 1'b1, 1'b0};
    rampTbl[8] = '{33, 0, 3, 1'b0, 1'b1};
    rampTbl[9] = '{34, 0, 3, 1'b0, 1'b0};

    startTbl[0] = '{4'd0,  32'd10, 1'b0, 1'b0, 32'd4,  32'd0};
    startTbl[1] = '{4'd1,  32'd1,  1'b0, 1'b0, 32'd4,  32'd0};
    startTbl[2] = '{4'd1,  32'd10, 1'b1, 1'b0, 32'd4,  32'd0};
    startTbl[3] = '{4'd9,  32'd10, 1'b0, 1'b0, 32'd4,  32'd0};
    startTbl[4] = '{4'd1,  32'd10, 1'b0, 1'b1, 32'd10, 32'd1};

    #3 rstn = 1'b0;
    #1 checkIdleOutputs("reset");
    #18 rstn = 1'b1;
    tick();

    // Single entry held for two periods of 10.
    writeEntry(0, 32'd3, 8'h55, 16'd2);
    applyStimulus(4'd1, 32'd10, 1'b0, 1'b0);
    checkOutput("single PULSE", PULSE, 32'd3);
    checkOutput("single SIZE", 32'(SIZE), 32'h55);
    checkOutput("single PERIOD", PERIOD, 32'd10);
    for (int k = 1; k <= 20; k++) begin
      checkOutput($sformatf("single ENABLE k=%0d", k), 32'(ENABLE), 32'd1);
      if (k < 20) tick();
    end
    checkOutput("single PULSE end", PULSE, 32'd3);
    checkOutput("single done early", 32'(done), 32'd0);
    tick();
    checkOutput("single ENABLE fall", 32'(ENABLE), 32'd0);
    checkOutput("single done pulse", 32'(done), 32'd1);
    checkOutput("single busy fall", 32'(busy), 32'd0);
    tick();
    checkOutput("single done one cycle", 32'(done), 32'd0);
    checkOutput("single busy after", 32'(busy), 32'd0);

    // Four-step ramp, one period of 8 per step.
    for (int i = 0; i < 4; i++)
      writeEntry(AW'(i), 32'(i + 1), 8'(8'h10 * (i + 1)), 16'd1);
    applyStimulus(4'd4, 32'd8, 1'b0, 1'b0);
    curK = 1;
    for (int v = 0; v < 10; v++) begin
      while (curK < rampTbl[v].k) begin
        tick();
        curK++;
      end
      checkOutput($sformatf("ramp PULSE k=%0d", curK), PULSE, rampTbl[v].expPulse);
      checkOutput($sformatf("ramp idx k=%0d", curK), 32'(cur_idx), 32'(rampTbl[v].expIdx));
      checkOutput($sformatf("ramp ENABLE k=%0d", curK), 32'(ENABLE), 32'(rampTbl[v].expEnable));
      checkOutput($sformatf("ramp done k=%0d", curK), 32'(done), 32'(rampTbl[v].expDone));
    end

    // Looping ramp, stop at pcnt=2 after the first wrap.
    applyStimulus(4'd4, 32'd8, 1'b1, 1'b0);
    ticks(31);
    checkOutput("loop idx k=32", 32'(cur_idx), 32'd3);
    tick();
    checkOutput("loop wrap idx", 32'(cur_idx), 32'd0);
    checkOutput("loop wrap PULSE", PULSE, 32'd1);
    checkOutput("loop wrap ENABLE", 32'(ENABLE), 32'd1);
    ticks(2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("loop stop ENABLE held", 32'(ENABLE), 32'd1);
    ticks(4);
    checkOutput("loop stop ENABLE k=40", 32'(ENABLE), 32'd1);
    checkOutput("loop stop busy k=40", 32'(busy), 32'd1);
    tick();
    checkOutput("loop stop ENABLE fall", 32'(ENABLE), 32'd0);
    checkOutput("loop stop busy fall", 32'(busy), 32'd0);
    checkOutput("loop stop no done", 32'(done), 32'd0);
    checkOutput("loop stop PULSE", PULSE, 32'd0);
    tick();
    checkOutput("loop stop no done later", 32'(done), 32'd0);

    // Stop arriving on the boundary cycle itself.
    applyStimulus(4'd2, 32'd4, 1'b0, 1'b0);
    ticks(3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("bstop ENABLE", 32'(ENABLE), 32'd0);
    checkOutput("bstop busy", 32'(busy), 32'd0);
    checkOutput("bstop done", 32'(done), 32'd0);
    checkOutput("bstop PULSE", PULSE, 32'd0);
    checkOutput("bstop idx", 32'(cur_idx), 32'd0);

    // Illegal starts, then one legal start.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(startTbl[v].num, startTbl[v].period, 1'b0, startTbl[v].stopIn);
      checkOutput($sformatf("start[%0d] busy", v), 32'(busy), 32'(startTbl[v].expBusy));
      checkOutput($sformatf("start[%0d] ENABLE", v), 32'(ENABLE), 32'(startTbl[v].expBusy));
      checkOutput($sformatf("start[%0d] PERIOD", v), PERIOD, startTbl[v].expPeriod);
      checkOutput($sformatf("start[%0d] PULSE", v), PULSE, startTbl[v].expPulse);
    end
    begin
      int n = 0;
      while (!done && n < 20) begin
        tick();
        n++;
      end
      checkOutput("legal start done", 32'(done), 32'd1);
    end
    tick();

    // Live write to e1 on the very cycle e1 is loaded.
    writeEntry(0, 32'd1, 8'h10, 16'd3);
    applyStimulus(4'd2, 32'd4, 1'b1, 1'b0);
    ticks(11);
    checkOutput("live PULSE k=12", PULSE, 32'd1);
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_pulse = 32'd7; cfg_size = 8'h20; cfg_reps = 16'd1;
    tick();
    cfg_we = 1'b0;
    checkOutput("live old e1 PULSE", PULSE, 32'd2);
    checkOutput("live old e1 idx", 32'(cur_idx), 32'd1);
    ticks(4);
    checkOutput("live wrap PULSE", PULSE, 32'd1);
    checkOutput("live wrap idx", 32'(cur_idx), 32'd0);
    ticks(12);
    checkOutput("live new e1 PULSE", PULSE, 32'd7);
    checkOutput("live new e1 idx", 32'(cur_idx), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    waitIdle("live stop", 10);
    checkOutput("live stop no done", 32'(done), 32'd0);

    // Asynchronous reset in the middle of a run.
    applyStimulus(4'd2, 32'd8, 1'b0, 1'b0);
    ticks(4);
    checkOutput("midrst PULSE before", PULSE, 32'd1);
    rstn = 1'b0;
    #1 checkIdleOutputs("midrst");
    rstn = 1'b1;
    tick();
    applyStimulus(4'd1, 32'd5, 1'b0, 1'b0);
    checkOutput("postrst PULSE", PULSE, 32'd0);
    checkOutput("postrst SIZE", 32'(SIZE), 32'd0);
    checkOutput("postrst ENABLE", 32'(ENABLE), 32'd1);
    checkOutput("postrst PERIOD", PERIOD, 32'd5);
    ticks(4);
    checkOutput("postrst ENABLE k=5", 32'(ENABLE), 32'd1);
    tick();
    checkOutput("postrst ENABLE fall", 32'(ENABLE), 32'd0);
    checkOutput("postrst done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pwm_sequencer.md
Name: pwm_sequencer

Overview:
Controller that sequences the PWM generator through a programmable table of duty-cycle steps, giving ramps, fades and pulse patterns. It owns the generator's PERIOD/PULSE/SIZE/ENABLE inputs. It changes duty settings only on period boundaries, which it tracks with its own period counter. It sits between the register/bus front-end, which writes the table and issues start/stop, and the pwm_generator instance.

Parameters:
N_ENTRIES, 8, number of table entries (power of 2, ≥2)
AW, $clog2(N_ENTRIES), table index width (derived; do not override)

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
cfg_we  input  1  table write strobe
cfg_addr  input  AW  table entry index for write
cfg_pulse  input  32  entry PULSE value
cfg_size  input  8  entry SIZE (PWM output level while high)
cfg_reps  input  16  number of periods the entry is held; 0 is treated as 1
period_i  input  32  PWM period in clk cycles, sampled at start
num_entries  input  AW+1  number of active entries (1..N_ENTRIES), sampled at start
loop_en  input  1  1 = wrap to entry 0 after the last entry; sampled at start
start  input  1  single-cycle start request
stop  input  1  single-cycle graceful stop request
PERIOD  output  32  to generator
PULSE  output  32  to generator
SIZE  output  8  to generator
ENABLE  output  1  to generator
busy  output  1  sequence running
done  output  1  one-cycle pulse on natural completion
cur_idx  output  AW  index of the entry currently applied

Behaviour:
- Reset: all outputs 0. Table entries reset to pulse=0, size=0, reps=0. State IDLE. All internal counters and flags 0.
- Table writes are accepted in any state on cfg_we. A write becomes visible at the entry's next load. If a write and a load hit the same entry in the same cycle, the pre-write value is loaded.
- States: IDLE, RUN.
- Start condition: in IDLE, start=1, stop=0, num_entries in 1..N_ENTRIES and period_i ≥ 2.
  - If any condition fails, start is ignored and the block stays in IDLE.
  - Any stop, including start and stop in the same cycle, blocks the start.
- IDLE→RUN: on the cycle after a valid start:
  - PERIOD=period_i; PULSE/SIZE = entry 0; cur_idx=0.
  - rep_cnt = max(reps0,1); pcnt=0.
  - ENABLE=1, busy=1.
  - num_entries and loop_en are latched at this point.
- RUN counting:
  - pcnt counts 0..PERIOD-1 each cycle and wraps to 0.
  - The boundary is the cycle where pcnt==PERIOD-1.
  - New values registered on the boundary edge take effect from the first cycle of the next period.
- At a boundary (priority order):
  1. stop_pending=1: ENABLE=0, busy=0, PULSE=SIZE=0, go IDLE. No done pulse.
  2. rep_cnt>1: decrement rep_cnt; keep the current entry.
  3. cur_idx < num_entries-1: cur_idx+1; load that entry; rep_cnt = max(reps,1).
  4. Last entry and loop_en=1: cur_idx=0; reload entry 0.
  5. Last entry and loop_en=0: ENABLE=0, busy=0, PULSE=SIZE=0, done=1 for one cycle, go IDLE.
- Stop handling:
  - stop in RUN sets stop_pending. The current period always completes; no truncated pulse.
  - stop arriving on the boundary cycle itself takes effect at that boundary.
  - stop_pending clears on entry to IDLE.
- start while RUN is ignored. The latched period_i, num_entries and loop_en do not change during RUN.
- cur_idx holds its last value in IDLE and resets only via rstn or the next start.
- Width rules:
  - pcnt and PERIOD are 32-bit unsigned.
  - rep_cnt is 16-bit; reps=0xFFFF holds 65535 periods.
  - Index comparison uses an AW+1-bit width.
- Async reset mid-RUN: every output returns to 0 immediately and the table is cleared.

Test Plan:
- Single entry: reset, write e0 {pulse=3, size=0x55, reps=2}, period_i=10, num=1, loop=0, start → ENABLE high for exactly 20 cycles starting 1 cycle after start; PULSE=3, SIZE=0x55 throughout; done pulses 1 cycle at ENABLE fall; busy=0 afterwards.
- Ramp: e0..e3 pulse=1,2,3,4, reps=1, period_i=8, num=4 → PULSE changes exactly every 8 cycles, aligned to pcnt wrap; cur_idx 0,1,2,3; done after 32 cycles.
- Loop + stop: same table with loop=1; let it wrap once (cur_idx 3→0), assert stop mid-period at pcnt=2 → ENABLE falls at the end of that period (6 cycles later); done stays 0; busy falls together with ENABLE.
- Illegal starts: start with num_entries=0, then with period_i=1, then start and stop in the same cycle → busy and ENABLE stay 0 and outputs are unchanged.
- Live write: during RUN on e0 (reps=3), write e1 pulse=7; at the e0→e1 boundary the write is issued in the same cycle as the load → the old e1 value is applied; on the next loop pass, pulse=7 is applied.
- Reset mid-run: assert rstn=0 with pcnt=4 → all outputs 0 asynchronously; a subsequent start with an unwritten table gives PULSE=0, SIZE=0, reps treated as 1.
